// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM states and widths for the multiply/divide unit
package muldiv_pkg;
  localparam int DATA_W = 32;
  localparam int CNT_W = $clog2(DATA_W) + 1;
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MFHI  = 3'd4,
    OP_MFLO  = 3'd5,
    OP_MTHI  = 3'd6,
    OP_MTLO  = 3'd7
  } op_e;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;
endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: unsigned shift-add multiply / restoring divide, one bit per step
module muldiv_core #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic         div,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);
  logic [W-1:0] d;
  logic [W:0]   sum;
  logic [W:0]   sh;
  logic         fit;
  always_comb begin
    sum = {1'b0, hi} + (lo[0] ? {1'b0, d} : '0);
    sh  = {hi, lo[W-1]};
    fit = sh >= {1'b0, d};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
      d  <= '0;
    end else if (load) begin
      hi <= '0;
      lo <= a;
      d  <= b;
    end else if (step) begin
      hi <= div ? (fit ? sh[W-1:0] - d : sh[W-1:0]) : sum[W:1];
      lo <= div ? {lo[W-2:0], fit} : {sum[0], lo[W-1:1]};
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/DIV with HI/LO registers and pipeline stall request
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         op_valid,
  input  logic [2:0]   op,
  input  logic         flush,
  input  logic [W-1:0] rs_val,
  input  logic [W-1:0] rt_val,
  output logic         busy,
  output logic         stall,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic [W-1:0] rd_data
);
  state_e           state, next;
  logic [CNT_W-1:0] cnt;
  logic             neg_q, neg_r, is_div;
  logic             issue, idle, start, sgn;
  logic [W-1:0]     abs_a, abs_b, core_hi, core_lo;
  logic [2*W-1:0]   prod;
  always_comb begin
    issue   = op_valid && !flush;
    idle    = state == IDLE;
    busy    = !idle;
    stall   = busy && issue;
    start   = issue && idle && !op[2];
    sgn     = !op[2] && !op[0];
    abs_a   = (sgn && rs_val[W-1]) ? -rs_val : rs_val;
    abs_b   = (sgn && rt_val[W-1]) ? -rt_val : rt_val;
    prod    = {core_hi, core_lo};
    rd_data = op == OP_MFHI ? hi : op == OP_MFLO ? lo : '0;
    next    = idle ? (start ? RUN : IDLE) : state == RUN ? (cnt == CNT_W'(1) ? FIX : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= next;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_div <= 1'b0;
    end else begin
      if (start) begin
        cnt    <= CNT_W'(W);
        // a zero divisor yields all-ones quotient regardless of signs
        neg_q  <= sgn && (rs_val[W-1] ^ rt_val[W-1]) && !(op[1] && rt_val == '0);
        neg_r  <= sgn && rs_val[W-1];
        is_div <= op[1];
      end
      if (state == RUN) cnt <= cnt - CNT_W'(1);
      if (issue && idle && op == OP_MTHI) hi <= rs_val;
      if (issue && idle && op == OP_MTLO) lo <= rs_val;
      if (state == FIX) begin
        if (is_div) begin
          lo <= neg_q ? -core_lo : core_lo;
          hi <= neg_r ? -core_hi : core_hi;
        end else begin
          {hi, lo} <= neg_q ? -prod : prod;
        end
      end
    end
  end
  muldiv_core #(.W(W)) u_core (
    .clk(clk),
    .reset(reset),
    .load(start),
    .step(state == RUN),
    .div(op[1] && start ? 1'b1 : (start ? 1'b0 : is_div)),
    .a(abs_a),
    .b(abs_b),
    .hi(core_hi),
    .lo(core_lo)
  );
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an arithmetic model
module tb_muldiv_unit;
  import muldiv_pkg::*;
  logic        clk = 0, reset = 1, op_valid = 0, flush = 0;
  logic [2:0]  op = 0;
  logic [31:0] rs_val = 0, rt_val = 0;
  logic        busy, stall;
  logic [31:0] hi, lo, rd_data;
  logic [31:0] mh = 0, ml = 0;
  int          passed = 0, total = 0;
  muldiv_unit #(.W(32)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .flush(flush),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .stall(stall),
    .hi(hi), .lo(lo), .rd_data(rd_data)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passed++;
  endtask
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] h, inout logic [31:0] l);
    longint p;
    int sa, sb;
    sa = a;
    sb = b;
    case (o)
      OP_MULT:  begin p = longint'(sa) * longint'(sb); {h, l} = p; end
      OP_MULTU: begin p = longint'({32'b0, a}) * longint'({32'b0, b}); {h, l} = p; end
      OP_DIV: begin
        if (b == 0) begin l = '1; h = a; end
        else if (a == 32'h8000_0000 && b == '1) begin l = 32'h8000_0000; h = 0; end
        else begin l = sa / sb; h = sa % sb; end
      end
      OP_DIVU: begin
        if (b == 0) begin l = '1; h = a; end
        else begin l = a / b; h = a % b; end
      end
      OP_MTHI: h = a;
      OP_MTLO: l = a;
      default: ;
    endcase
  endfunction
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int n;
    @(negedge clk);
    op_valid = 1; op = o; rs_val = a; rt_val = b;
    #1 check({tag, " stall_idle"}, 32'(stall), 0);
    model(o, a, b, mh, ml);
    @(negedge clk);
    op_valid = 0;
    if (!o[2]) begin
      n = 0;
      while (busy && n < 100) begin n++; @(negedge clk); end
      check({tag, " latency"}, n, 33);
    end
    check({tag, " hi"}, hi, mh);
    check({tag, " lo"}, lo, ml);
  endtask
  task automatic mf_check(input string tag);
    @(negedge clk);
    op_valid = 1; op = OP_MFHI;
    #1 check({tag, " mfhi"}, rd_data, mh);
    op = OP_MFLO;
    #1 check({tag, " mflo"}, rd_data, ml);
    op_valid = 0;
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 0;
      1: return 1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      5: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction
  initial begin
    int n;
    logic [2:0] ops [6] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};
    repeat (2) @(negedge clk);
    reset = 0;
    check("reset busy", 32'(busy), 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    run_op("mult -3", OP_MULT, 7, 32'hFFFF_FFFD);
    run_op("multu", OP_MULTU, 7, 32'hFFFF_FFFD);
    run_op("divu 100/7", OP_DIVU, 100, 7);
    run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 2);
    run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu 5/0", OP_DIVU, 5, 0);
    run_op("div -5/0", OP_DIV, 32'hFFFF_FFFB, 0);
    mf_check("after div0");
    @(negedge clk);
    op_valid = 1; op = OP_MULT; rs_val = 3; rt_val = 4;
    @(negedge clk);
    op = OP_MFLO;
    n = 0;
    while (stall && n < 100) begin n++; @(negedge clk); end
    check("mflo stall cycles", n, 33);
    #1 check("mflo stall released", 32'(stall), 0);
    check("mflo rd_data", rd_data, 12);
    op_valid = 0;
    mh = 0; ml = 12;
    run_op("mthi", OP_MTHI, 32'hDEAD_BEEF, 0);
    @(negedge clk);
    op_valid = 1; flush = 1; op = OP_MTLO; rs_val = 32'h1234_5678;
    #1 check("mtlo flush stall", 32'(stall), 0);
    @(negedge clk);
    op_valid = 0; flush = 0;
    check("mtlo flush lo", lo, ml);
    @(negedge clk);
    op_valid = 1; op = OP_DIV; rs_val = 1000; rt_val = 3;
    @(negedge clk);
    op_valid = 0;
    repeat (9) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("abort busy", 32'(busy), 0);
    check("abort hi", hi, 0);
    check("abort lo", lo, 0);
    mh = 0; ml = 0;
    run_op("multu 2*2", OP_MULTU, 2, 2);
    for (int i = 0; i < 30; i++) begin
      run_op($sformatf("rnd%0d", i), ops[$urandom_range(0, 5)], pick(), pick());
      if (i % 5 == 0) mf_check($sformatf("rnd%0d", i));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
